// File: rtl/full_adder_2bit.sv
// Purpose : two-bit ripple-carry adder {A1,A0}+{B1,B0}+C0 with registered sum, ripple and carry-out.
// Latency : one clock from operand sample to S0/C1/S1/C2; one new add accepted every cycle.
// Backpressure: none; no handshake, every edge overwrites the previous result.
module full_adder_2bit (
  input  logic clk,
  input  logic rst,
  input  logic A0,
  input  logic B0,
  input  logic C0,
  input  logic A1,
  input  logic B1,
  output logic S0,
  output logic C1,
  output logic S1,
  output logic C2
);

  logic s0_d, c1_d, s1_d, c2_d;
  logic s0_q, c1_q, s1_q, c2_q;

  // Bit-0 full adder feeds its carry straight into the bit-1 full adder.
  always_comb begin
    s0_d = A0 ^ B0 ^ C0;
    c1_d = (A0 & B0) | (A0 & C0) | (B0 & C0);
    s1_d = A1 ^ B1 ^ c1_d;
    c2_d = (A1 & B1) | (A1 & c1_d) | (B1 & c1_d);
  end

  // Result register; reset wins over the operands on the edge it is sampled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_q <= 1'b0;
      c1_q <= 1'b0;
      s1_q <= 1'b0;
      c2_q <= 1'b0;
    end else begin
      s0_q <= s0_d;
      c1_q <= c1_d;
      s1_q <= s1_d;
      c2_q <= c2_d;
    end
  end

  // C1 is exposed so the ripple carry can be observed, not fed back in.
  assign S0 = s0_q;
  assign C1 = c1_q;
  assign S1 = s1_q;
  assign C2 = c2_q;

endmodule

// File: tb/tb_full_adder_2bit.sv
// Purpose : directed and exhaustive checks of full_adder_2bit.
// Latency : expects results one clock after operands are applied.
// Backpressure: not applicable; stimulus is one add per cycle.
module tb_full_adder_2bit;

  logic clk;
  logic rst;
  logic A0, B0, C0, A1, B1;
  logic S0, C1, S1, C2;

  int checks;
  int errors;

  typedef struct {
    string     name;
    logic      a0, b0, c0, a1, b1;
    logic      s0, c1, s1, c2;
  } vec_t;

  vec_t vecs[4];

  full_adder_2bit dut (
    .clk (clk),
    .rst (rst),
    .A0  (A0),
    .B0  (B0),
    .C0  (C0),
    .A1  (A1),
    .B1  (B1),
    .S0  (S0),
    .C1  (C1),
    .S1  (S1),
    .C2  (C2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs packed as {C2,S1,C1,S0}.
  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {C2,S1,C1,S0}=%b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic a0, input logic b0, input logic c0, input logic a1, input logic b1);
    A0 = a0; B0 = b0; C0 = c0; A1 = a1; B1 = b1;
  endtask

  initial begin
    logic [4:0] v;
    logic [1:0] opa, opb;
    logic       cin;
    logic [2:0] sum;
    logic       maj;
    logic [3:0] held;

    checks = 0;
    errors = 0;

    vecs[0] = '{"a3_b0",     1'b1, 1'b0, 1'b0, 1'b1, 1'b0,  1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{"a0_b3",     1'b0, 1'b1, 1'b0, 1'b0, 1'b1,  1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{"a1_b3",     1'b1, 1'b1, 1'b0, 1'b0, 1'b1,  1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{"a3_b3_c1",  1'b1, 1'b1, 1'b1, 1'b1, 1'b1,  1'b1, 1'b1, 1'b1, 1'b1};

    // Initial reset with random-looking operands present.
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    check4("initial_reset", {C2, S1, C1, S0}, 4'b0000);
    rst = 1'b0;

    // Directed vectors.
    foreach (vecs[i]) begin
      drive(vecs[i].a0, vecs[i].b0, vecs[i].c0, vecs[i].a1, vecs[i].b1);
      @(posedge clk); #1;
      check4(vecs[i].name, {C2, S1, C1, S0}, {vecs[i].c2, vecs[i].s1, vecs[i].c1, vecs[i].s0});
    end

    // Mid-stream reset with all inputs at 1: reset must win on that edge.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    check4("midstream_reset", {C2, S1, C1, S0}, 4'b0000);
    rst = 1'b0;
    #3;
    check4("reset_hold_between_edges", {C2, S1, C1, S0}, 4'b0000);
    @(posedge clk); #1;
    check4("first_after_reset", {C2, S1, C1, S0}, 4'b1111);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    check4("hold_after_input_change", {C2, S1, C1, S0}, 4'b1111);
    @(posedge clk); #1;
    check4("zero_add", {C2, S1, C1, S0}, 4'b0000);

    // Exhaustive sweep; operands disturbed mid-cycle must not leak into outputs.
    for (int i = 0; i < 32; i++) begin
      v   = i[4:0];
      opa = v[1:0];
      opb = v[3:2];
      cin = v[4];
      drive(opa[0], opb[0], cin, opa[1], opb[1]);
      @(posedge clk); #1;
      sum = {1'b0, opa} + {1'b0, opb} + {2'b00, cin};
      maj = (opa[0] & opb[0]) | (opa[0] & cin) | (opb[0] & cin);
      check4($sformatf("sweep_%0d", i), {C2, S1, C1, S0}, {sum[2], sum[1], maj, sum[0]});
      held = {C2, S1, C1, S0};
      drive(~opa[0], ~opb[0], ~cin, ~opa[1], ~opb[1]);
      #3;
      check4($sformatf("sweep_hold_%0d", i), {C2, S1, C1, S0}, {sum[2], sum[1], maj, sum[0]});
      if (held !== {C2, S1, C1, S0}) begin
        checks++;
        errors++;
        $display("FAIL sweep_stable_%0d: got %b expected %b", i, {C2, S1, C1, S0}, held);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
